// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_rx
//   Serial-to-parallel UART receiver. The frame is 1 start bit, 8 data bits
//   (LSB first), 1 stop bit and no parity. A low pulse shorter than half a bit
//   is treated as a glitch. A stop bit sampled low raises a framing-error
//   strobe. After a framing error the receiver stays disarmed until the line
//   has gone high again, so a line held low (break) reports only one error.
//
//   Parameters
//     CLKS_PER_BIT  i_Clock cycles per bit (f_clk / baud), must be >= 8
//
//   Ports
//     i_Clock         system clock, rising edge
//     i_Rst_n         asynchronous active-low reset
//     i_RX_Serial     raw serial line, asynchronous to i_Clock, idles high
//     o_RX_DV         one-cycle strobe: o_RX_Byte holds a newly received byte
//     o_RX_Byte       last correctly received byte
//     o_RX_Active     high from start-bit acceptance until the end of cleanup
//     o_RX_Frame_Err  one-cycle strobe: the stop bit was sampled low
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_RX_Frame_Err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CLEANUP
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          armed, armed_nxt;
  logic          dv_nxt, err_nxt, active_nxt;
  logic [7:0]    byte_nxt;

  // Two-flop synchronizer. Both flops reset to the idle (high) level so that
  // reset release never looks like a start bit.
  logic rx_meta, rx_s;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_RX_Serial;
      rx_s    <= rx_meta;
    end
  end

  logic half_tick, bit_tick;
  assign half_tick = (clk_cnt == HALF);
  assign bit_tick  = (clk_cnt == LAST);

  // State and datapath registers. Outputs are registered, so the strobes
  // come straight from flops.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state          <= S_IDLE;
      clk_cnt        <= '0;
      bit_idx        <= '0;
      shift          <= '0;
      armed          <= 1'b1;
      o_RX_DV        <= 1'b0;
      o_RX_Byte      <= 8'h00;
      o_RX_Active    <= 1'b0;
      o_RX_Frame_Err <= 1'b0;
    end else begin
      state          <= state_nxt;
      clk_cnt        <= clk_cnt_nxt;
      bit_idx        <= bit_idx_nxt;
      shift          <= shift_nxt;
      armed          <= armed_nxt;
      o_RX_DV        <= dv_nxt;
      o_RX_Byte      <= byte_nxt;
      o_RX_Active    <= active_nxt;
      o_RX_Frame_Err <= err_nxt;
    end
  end

  // Next-state and sequencing: bit timing and capture of the data bits.
  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    case (state)
      S_IDLE: begin
        clk_cnt_nxt = '0;
        bit_idx_nxt = '0;
        if (!rx_s && armed) state_nxt = S_START;
      end
      // The start bit is re-checked at its middle. If the line is high
      // again, the low level was a glitch and we go back to idle.
      S_START: begin
        if (half_tick) begin
          clk_cnt_nxt = '0;
          state_nxt   = rx_s ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end
      // The count restarts at mid start bit, so every full bit period
      // after that lands in the middle of a data bit.
      S_DATA: begin
        if (bit_tick) begin
          clk_cnt_nxt        = '0;
          shift_nxt[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
            bit_idx_nxt = '0;
            state_nxt   = S_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          clk_cnt_nxt = '0;
          state_nxt   = S_CLEANUP;
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end
      S_CLEANUP: state_nxt = S_IDLE;
      default: begin
        state_nxt   = S_IDLE;
        clk_cnt_nxt = '0;
        bit_idx_nxt = '0;
      end
    endcase
  end

  // Output decode. The strobes default low, so each one lasts a single cycle.
  // The stop-bit decision makes DV and Frame_Err mutually exclusive.
  always_comb begin
    dv_nxt     = 1'b0;
    err_nxt    = 1'b0;
    active_nxt = o_RX_Active;
    byte_nxt   = o_RX_Byte;
    // The receiver re-arms as soon as the line is seen high again.
    armed_nxt  = armed | rx_s;
    case (state)
      S_START: begin
        if (half_tick && !rx_s) active_nxt = 1'b1;
      end
      S_STOP: begin
        if (bit_tick) begin
          if (rx_s) begin
            byte_nxt = shift;
            dv_nxt   = 1'b1;
          end else begin
            err_nxt   = 1'b1;
            armed_nxt = 1'b0;
          end
        end
      end
      S_CLEANUP: active_nxt = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int  CPB     = 16;
  localparam int  HALF    = (CPB - 1) / 2;
  localparam real TCLK    = 10.0;
  localparam real TBIT    = CPB * TCLK;
  localparam int  LAT_REF = 2 + HALF + 1 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       dv, active, ferr;
  logic [7:0] rbyte;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock       (clk),
    .i_Rst_n       (rst_n),
    .i_RX_Serial   (rx),
    .o_RX_DV       (dv),
    .o_RX_Byte     (rbyte),
    .o_RX_Active   (active),
    .o_RX_Frame_Err(ferr)
  );

  // Expected receiver events, in stream order.
  typedef struct {
    logic       err;
    logic [7:0] data;
    int         fall_cyc;   // -1: latency not checked
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [7:0] model_last = 8'h00;  // last good byte the receiver should hold
  logic       prev_dv = 1'b0, prev_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: consume one expected event for every strobe from the DUT.
  always @(negedge clk) begin
    if (dv || ferr) begin
      check("dv_err_exclusive", {31'd0, dv & ferr}, 32'd0);
      check("pulse_one_cycle", {31'd0, (dv & prev_dv) | (ferr & prev_err)}, 32'd0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: dv=%0b err=%0b byte=%h expected none", dv, ferr, rbyte);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_kind_err", {31'd0, ferr}, {31'd0, e.err});
        check("rx_byte", {24'd0, rbyte}, {24'd0, e.data});
        if (e.fall_cyc >= 0) begin
          int lat;
          lat = cyc - e.fall_cyc;
          tests++;
          if (lat < LAT_REF - 1 || lat > LAT_REF + 1) begin
            fails++;
            $display("FAIL latency: got %0d expected %0d +/-1", lat, LAT_REF);
          end
        end
      end
    end
    prev_dv  <= dv;
    prev_err <= ferr;
  end

  // Serial driver acting as the transmitter. The expected event is queued
  // before the start bit goes out.
  task automatic send_frame(input logic [7:0] d, input logic stop, input real bt, input logic chk_lat);
    exp_t e;
    e.err      = ~stop;
    e.data     = stop ? d : model_last;
    e.fall_cyc = chk_lat ? cyc : -1;
    if (stop) model_last = d;
    sb.push_back(e);
    rx = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bt);
    end
    rx = stop;
    #(bt);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dv"}, {31'd0, dv}, 32'd0);
    check({tag, "_byte"}, {24'd0, rbyte}, 32'd0);
    check({tag, "_active"}, {31'd0, active}, 32'd0);
    check({tag, "_ferr"}, {31'd0, ferr}, 32'd0);
  endtask

  initial begin
    logic       saw_active;
    logic [7:0] c3;
    // reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: single frame with latency check
    @(negedge clk);
    send_frame(8'hA5, 1'b1, TBIT, 1'b1);
    rx = 1'b1;
    #(2 * TBIT);

    // 2: short low glitch must be ignored
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    saw_active = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      saw_active |= active;
    end
    check("glitch_active", {31'd0, saw_active}, 32'd0);
    send_frame(8'h3C, 1'b1, TBIT, 1'b0);
    rx = 1'b1;
    #(2 * TBIT);

    // 3: framing error, then break, then recovery
    send_frame(8'h81, 1'b0, TBIT, 1'b0);
    #(40 * TBIT);
    check("byte_kept_after_err", {24'd0, rbyte}, 32'h3C);
    rx = 1'b1;
    #(2 * TBIT);
    send_frame(8'h55, 1'b1, TBIT, 1'b0);
    rx = 1'b1;
    #(2 * TBIT);

    // 4: back-to-back frames
    send_frame(8'h00, 1'b1, TBIT, 1'b0);
    send_frame(8'hFF, 1'b1, TBIT, 1'b0);
    send_frame(8'h7E, 1'b1, TBIT, 1'b0);
    rx = 1'b1;
    #(2 * TBIT);

    // 5: reset in the middle of data bit 4 of 8'hC3
    @(negedge clk);
    c3 = 8'hC3;
    rx = 1'b0;
    #(TBIT);
    for (int i = 0; i < 4; i++) begin
      rx = c3[i];
      #(TBIT);
    end
    rx = c3[4];
    #(TBIT / 2);
    check("active_mid_frame", {31'd0, active}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    model_last = 8'h00;
    rx = 1'b1;
    #(3 * TBIT);
    @(negedge clk);
    rst_n = 1'b1;
    #(2 * TBIT);
    send_frame(8'h12, 1'b1, TBIT, 1'b0);
    rx = 1'b1;
    #(2 * TBIT);

    // 6: random bytes with +/-2% baud skew and random idle gaps
    for (int n = 0; n < 150; n++) begin
      real skew, bt;
      skew = (real'($urandom_range(0, 400)) - 200.0) / 10000.0;
      bt   = TBIT * (1.0 + skew);
      send_frame(8'($urandom_range(0, 255)), 1'b1, bt, 1'b0);
      rx = 1'b1;
      #(bt * real'($urandom_range(0, 2)) + real'($urandom_range(0, 9)));
    end
    rx = 1'b1;

    // drain: every queued event must have shown up
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_pulse: got none expected err=%0b byte=%h", e.err, e.data);
    end
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
